// File: rtl/conv_pkg.sv
// ----------------------------------------------------------------------------
// conv_pkg
// Shared definitions for the convolution loop sequencer and the convolution
// address controller: sequencer state encoding, default layer dimensions and
// a helper that flattens an output pixel position into a buffer address.
// ----------------------------------------------------------------------------
package conv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

    localparam int DEF_K        = 5;
    localparam int DEF_IN_SIZE  = 32;
    localparam int DEF_OUT_SIZE = 28;
    localparam int DEF_IN_CH    = 1;
    localparam int DEF_OUT_CH   = 6;
    localparam int DEF_N_LANES  = 4;
    localparam int DEF_PIPE_LAT = 9;

    // Row-major output buffer address of pixel (row, col).
    function automatic logic [15:0] pixel_addr(input logic [7:0]  row,
                                               input logic [7:0]  col,
                                               input logic [15:0] row_pitch);
        pixel_addr = {8'd0, row} * row_pitch + {8'd0, col};
    endfunction

endpackage

// File: rtl/pipe_delay.sv
// ----------------------------------------------------------------------------
// pipe_delay
// Fixed-latency resettable shift register. A word presented on din appears on
// dout exactly DEPTH clock edges later. The line shifts every cycle, so the
// latency never stretches, whatever the producer is doing.
//
// Ports
//   clock    in   1      rising-edge clock
//   reset_n  in   1      synchronous active-low reset, clears every stage
//   din      in   WIDTH  word entering the line
//   dout     out  WIDTH  word leaving the line (last stage)
// ----------------------------------------------------------------------------
module pipe_delay #(
    parameter int WIDTH = 25,
    parameter int DEPTH = 9
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage [DEPTH];

    // Shift chain: stage 0 captures din, every other stage takes its
    // predecessor. Reset wipes all stages so no stale word can emerge.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int s = 0; s < DEPTH; s++) begin
                stage[s] <= '0;
            end
        end else begin
            stage[0] <= din;
            for (int s = 1; s < DEPTH; s++) begin
                stage[s] <= stage[s-1];
            end
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/conv_loop_sequencer.sv
// ----------------------------------------------------------------------------
// conv_loop_sequencer
// Walks the convolution loop nest m > r > c > n > i > j (outermost first) and
// presents each tuple to the address controller. Flags the first and last tap
// of every output pixel for the accumulator and, PIPE_LAT cycles after the
// last tap, announces the finished pixel (channel + address) to the output
// buffer. One layer pass runs from an accepted start to the done pulse.
//
// Ports
//   clock       in   1   rising-edge clock
//   reset_n     in   1   synchronous active-low reset
//   start       in   1   begins a pass when idle, ignored otherwise
//   stall       in   1   hold iterators, no issue this cycle
//   busy        out  1   pass in progress (RUN, DRAIN, DONE)
//   done        out  1   one-cycle pulse ending the pass
//   m,r,c,n     out  8   output channel, row, col, input channel (x N_LANES)
//   i,j         out  4   kernel row, kernel col
//   iter_valid  out  1   m..j form a live tuple this cycle
//   first_tap   out  1   live tuple is the first tap of its pixel
//   last_tap    out  1   live tuple is the last tap of its pixel
//   out_valid   out  1   last_tap delayed by PIPE_LAT cycles
//   out_addr    out  16  r*OUT_SIZE+c of the delayed pixel
//   out_m       out  8   m of the delayed pixel
// ----------------------------------------------------------------------------
module conv_loop_sequencer
    import conv_pkg::*;
#(
    parameter int K        = DEF_K,
    parameter int IN_SIZE  = DEF_IN_SIZE,
    parameter int OUT_SIZE = DEF_OUT_SIZE,
    parameter int IN_CH    = DEF_IN_CH,
    parameter int OUT_CH   = DEF_OUT_CH,
    parameter int N_LANES  = DEF_N_LANES,
    parameter int PIPE_LAT = DEF_PIPE_LAT
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic        stall,
    output logic        busy,
    output logic        done,
    output logic [7:0]  m,
    output logic [7:0]  r,
    output logic [7:0]  c,
    output logic [7:0]  n,
    output logic [3:0]  i,
    output logic [3:0]  j,
    output logic        iter_valid,
    output logic        first_tap,
    output logic        last_tap,
    output logic        out_valid,
    output logic [15:0] out_addr,
    output logic [7:0]  out_m
);

    localparam logic [3:0]  J_LAST     = 4'(K - 1);
    localparam logic [3:0]  I_LAST     = 4'(K - 1);
    localparam logic [7:0]  N_LAST     = 8'((IN_CH - 1) * N_LANES);
    localparam logic [7:0]  N_STEP     = 8'(N_LANES);
    localparam logic [7:0]  C_LAST     = 8'(OUT_SIZE - 1);
    localparam logic [7:0]  R_LAST     = 8'(OUT_SIZE - 1);
    localparam logic [7:0]  M_LAST     = 8'(OUT_CH - 1);
    localparam logic [15:0] ROW_PITCH  = 16'(OUT_SIZE);
    // DRAIN covers the cycles between the final issue and the cycle in which
    // the final pixel leaves the delay line; DONE coincides with that cycle.
    localparam logic [7:0]  DRAIN_LAST = 8'(PIPE_LAT - 2);
    localparam int          PIPE_W     = 1 + 8 + 16;

    // The input map must be at least as wide as the output map, otherwise the
    // controller would address pixels outside the input buffer.
    if (OUT_SIZE > IN_SIZE) begin : g_bad_dims
        $error("conv_loop_sequencer: OUT_SIZE exceeds IN_SIZE");
    end

    seq_state_t        state;
    seq_state_t        state_next;
    logic [7:0]        drain_cnt;
    logic              issue;
    logic              j_wrap;
    logic              i_wrap;
    logic              n_wrap;
    logic              c_wrap;
    logic              r_wrap;
    logic              final_tuple;
    logic [PIPE_W-1:0] pipe_in;
    logic [PIPE_W-1:0] pipe_out;

    // A tuple issues on every unstalled RUN cycle. The wrap terms cascade so
    // each one is only true when every inner loop is also at its last value.
    assign issue       = (state == ST_RUN) && !stall;
    assign j_wrap      = (j == J_LAST);
    assign i_wrap      = j_wrap && (i == I_LAST);
    assign n_wrap      = i_wrap && (n == N_LAST);
    assign c_wrap      = n_wrap && (c == C_LAST);
    assign r_wrap      = c_wrap && (r == R_LAST);
    assign final_tuple = r_wrap && (m == M_LAST);

    // State register.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and flag decode. iter_valid and the tap flags combine the
    // registered iterators with this cycle's stall so a stalled cycle never
    // shows a live tuple.
    always_comb begin
        state_next = state;
        busy       = (state != ST_IDLE);
        done       = (state == ST_DONE);
        iter_valid = issue;
        first_tap  = issue && (n == 8'd0) && (i == 4'd0) && (j == 4'd0);
        last_tap   = issue && (n == N_LAST) && (i == I_LAST) && (j == J_LAST);
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (issue && final_tuple) begin
                    state_next = (PIPE_LAT > 1) ? ST_DRAIN : ST_DONE;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt == DRAIN_LAST) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Counts cycles spent in DRAIN; held at zero everywhere else.
    always_ff @(posedge clock) begin
        if (!reset_n || state != ST_DRAIN) begin
            drain_cnt <= 8'd0;
        end else begin
            drain_cnt <= drain_cnt + 8'd1;
        end
    end

    // Cascaded wrap counters. They only move on an issue, and the final
    // tuple wraps every level, leaving all iterators at zero for the next pass.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            m <= 8'd0;
            r <= 8'd0;
            c <= 8'd0;
            n <= 8'd0;
            i <= 4'd0;
            j <= 4'd0;
        end else if (issue) begin
            j <= j_wrap ? 4'd0 : j + 4'd1;
            if (j_wrap) begin
                i <= i_wrap ? 4'd0 : i + 4'd1;
            end
            if (i_wrap) begin
                n <= n_wrap ? 8'd0 : n + N_STEP;
            end
            if (n_wrap) begin
                c <= c_wrap ? 8'd0 : c + 8'd1;
            end
            if (c_wrap) begin
                r <= r_wrap ? 8'd0 : r + 8'd1;
            end
            if (r_wrap) begin
                m <= final_tuple ? 8'd0 : m + 8'd1;
            end
        end
    end

    // Only completed pixels enter the line; everything else shifts in zeros,
    // which keeps out_addr/out_m at zero whenever out_valid is low.
    assign pipe_in = last_tap ? {1'b1, m, pixel_addr(r, c, ROW_PITCH)} : '0;

    pipe_delay #(
        .WIDTH (PIPE_W),
        .DEPTH (PIPE_LAT)
    ) u_pipe_delay (
        .clock   (clock),
        .reset_n (reset_n),
        .din     (pipe_in),
        .dout    (pipe_out)
    );

    assign {out_valid, out_m, out_addr} = pipe_out;

endmodule
